mem_stage_unit: RTL and testbench

MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

---
 rtl/mem_stage_unit_pkg.sv | 29 ++
 rtl/mem_stage_unit_wb_reg.sv | 27 ++
 rtl/mem_stage_unit.sv | 156 +++++++++++++++
 tb/tb_mem_stage_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_unit_pkg.sv
// Shared settings for the memory stage: datapath widths, the WB-side bundle
// type and the data-memory address helper.
//   WORD_WIDTH      : width of ALU results, addresses and memory data
//   REG_FILE_DEPTH  : width of the destination-register index
package mem_stage_unit_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int REG_FILE_DEPTH = 4;

   typedef struct packed {
      logic [REG_FILE_DEPTH-1:0] dst;
      logic [WORD_WIDTH-1:0]     alu_res;
      logic [WORD_WIDTH-1:0]     mem_result;
      logic                      mem_read;
      logic                      wb_en;
   } wb_bus_t;

   // Word-aligned data-memory address: ALU result minus the memory base offset.
   function automatic logic [WORD_WIDTH-1:0] calc_mem_addr(
      input logic [WORD_WIDTH-1:0] alu_res,
      input logic [WORD_WIDTH-1:0] offset
   );
      logic [WORD_WIDTH-1:0] addr;
      addr      = alu_res - offset;
      addr[1:0] = 2'b00;
      return addr;
   endfunction

endpackage

// File: rtl/mem_stage_unit_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst : clock and synchronous active-high reset
//   bubble   : 1 = insert a bubble (clear WB enable and load select, hold the rest)
//   d        : next WB bundle
//   q        : registered WB bundle
module mem_wb_reg
   import mem_stage_unit_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    bubble,
   input  wb_bus_t d,
   output wb_bus_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (bubble) begin
         q.wb_en    <= 1'b0;
         q.mem_read <= 1'b0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory pipeline stage with a request/ack data-memory port.
// A load or store freezes the upstream pipeline while the request is
// outstanding; a watchdog aborts an access that is never acknowledged.
//   clk, rst                      : clock, synchronous active-high reset
//   dst_in .. WB_en_in            : instruction from the EXE/MEM register
//   mem_req/we/addr/wdata         : request to data memory (valid only while busy)
//   mem_rdata, mem_ack            : memory response
//   freeze                        : stall PC, IF/ID, ID/EXE and EXE/MEM registers
//   dst_out .. WB_en_out          : MEM/WB register outputs
//   err_out                       : sticky access-timeout flag
//
// state | meaning
// IDLE  | no access in flight; accepts a load/store from the pipeline
// BUSY  | request outstanding, waiting for mem_ack or timeout
// DONE  | access finished; pipeline released for one cycle, WB loads the result
module mem_stage_unit
   import mem_stage_unit_pkg::*;
#(
   parameter int unsigned ADDR_OFFSET = 1024,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_FILE_DEPTH-1:0] dst_in,
   input  logic [WORD_WIDTH-1:0]     ALU_res_in,
   input  logic [WORD_WIDTH-1:0]     val_Rm_in,
   input  logic                      mem_read_in,
   input  logic                      mem_write_in,
   input  logic                      WB_en_in,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [WORD_WIDTH-1:0]     mem_addr,
   output logic [WORD_WIDTH-1:0]     mem_wdata,
   input  logic [WORD_WIDTH-1:0]     mem_rdata,
   input  logic                      mem_ack,
   output logic                      freeze,
   output logic [REG_FILE_DEPTH-1:0] dst_out,
   output logic [WORD_WIDTH-1:0]     ALU_res_out,
   output logic [WORD_WIDTH-1:0]     mem_result_out,
   output logic                      mem_read_out,
   output logic                      WB_en_out,
   output logic                      err_out
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [1:0]            state;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  armed;
   logic [WORD_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic                  is_read_q;
   logic [WORD_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic    start;
   logic    busy;
   logic    timeout_hit;
   wb_bus_t wb_d;
   wb_bus_t wb_q;

   // The cycle right after reset never starts an access, so freeze and
   // mem_req are guaranteed low then even if the upstream inputs lag.
   assign start       = (state == ST_IDLE) && armed && (mem_read_in || mem_write_in);
   assign busy        = (state == ST_BUSY);
   // Terminal count: this no-ack BUSY cycle is the TIMEOUT-th one.
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

   assign freeze    = start || busy;
   assign mem_req   = busy;
   assign mem_we    = busy && we_q;
   assign mem_addr  = busy ? addr_q  : '0;
   assign mem_wdata = busy ? wdata_q : '0;
   assign err_out   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         armed     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         is_read_q <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q    <= calc_mem_addr(ALU_res_in, WORD_WIDTH'(ADDR_OFFSET));
                  wdata_q   <= val_Rm_in;
                  // A simultaneous read and write request is executed as a write.
                  we_q      <= mem_write_in;
                  is_read_q <= mem_read_in && !mem_write_in;
                  rdata_q   <= '0;
                  wait_cnt  <= '0;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  if (is_read_q) begin
                     rdata_q <= mem_rdata;
                  end
                  state <= ST_DONE;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // The EXE/MEM register is still frozen during DONE, so the live inputs
   // still describe the finished memory instruction when WB loads it.
   always_comb begin
      wb_d            = '0;
      wb_d.dst        = dst_in;
      wb_d.alu_res    = ALU_res_in;
      wb_d.mem_result = (state == ST_DONE) ? rdata_q : '0;
      wb_d.mem_read   = mem_read_in;
      wb_d.wb_en      = WB_en_in;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk    (clk),
      .rst    (rst),
      .bubble (freeze),
      .d      (wb_d),
      .q      (wb_q)
   );

   assign dst_out        = wb_q.dst;
   assign ALU_res_out    = wb_q.alu_res;
   assign mem_result_out = wb_q.mem_result;
   assign mem_read_out   = wb_q.mem_read;
   assign WB_en_out      = wb_q.wb_en;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: the bench plays the upstream pipeline (it holds the
// instruction while frozen) and the data memory, and predicts every cycle's
// outputs from a per-instruction schedule.
module tb_mem_stage_unit;
   import mem_stage_unit_pkg::*;

   localparam int W   = WORD_WIDTH;
   localparam int D   = REG_FILE_DEPTH;
   localparam int TO  = 4;
   localparam int OFF = 1024;

   logic         clk = 1'b0;
   logic         rst;
   logic [D-1:0] dst_in;
   logic [W-1:0] ALU_res_in, val_Rm_in;
   logic         mem_read_in, mem_write_in, WB_en_in;
   logic         mem_req, mem_we;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
   logic         mem_ack, freeze;
   logic [D-1:0] dst_out;
   logic [W-1:0] ALU_res_out, mem_result_out;
   logic         mem_read_out, WB_en_out, err_out;

   always #5 clk = ~clk;

   mem_stage_unit #(.ADDR_OFFSET(OFF), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .dst_in(dst_in), .ALU_res_in(ALU_res_in),
      .val_Rm_in(val_Rm_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .WB_en_in(WB_en_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
      .dst_out(dst_out), .ALU_res_out(ALU_res_out), .mem_result_out(mem_result_out),
      .mem_read_out(mem_read_out), .WB_en_out(WB_en_out), .err_out(err_out)
   );

   typedef struct packed {
      logic         rd;
      logic         wr;
      logic         wben;
      logic [D-1:0] dst;
      logic [W-1:0] alu;
      logic [W-1:0] val;
   } ins_t;

   int checks = 0;
   int failures = 0;

   // expectations for the current cycle
   logic         chk_en = 1'b0;
   logic         e_freeze, e_req, e_we;
   logic [W-1:0] e_addr, e_wdata;
   // model of the MEM/WB register and the error flag
   logic [D-1:0] m_dst;
   logic [W-1:0] m_alu, m_res;
   logic         m_rd, m_en, m_err;

   int           fz_cnt = 0;
   logic [W-1:0] obs_addr = '0, obs_wdata = '0;
   logic         obs_we = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("freeze",         W'(freeze),       W'(e_freeze));
         check("mem_req",        W'(mem_req),      W'(e_req));
         check("mem_we",         W'(mem_we),       W'(e_we));
         check("mem_addr",       mem_addr,         e_addr);
         check("mem_wdata",      mem_wdata,        e_wdata);
         check("dst_out",        W'(dst_out),      W'(m_dst));
         check("ALU_res_out",    ALU_res_out,      m_alu);
         check("mem_result_out", mem_result_out,   m_res);
         check("mem_read_out",   W'(mem_read_out), W'(m_rd));
         check("WB_en_out",      W'(WB_en_out),    W'(m_en));
         check("err_out",        W'(err_out),      W'(m_err));
         if (freeze) fz_cnt++;
         if (mem_req) begin
            obs_addr  = mem_addr;
            obs_we    = mem_we;
            obs_wdata = mem_wdata;
         end
      end
   end

   function automatic ins_t mk(input logic rd, input logic wr, input logic wben,
                               input logic [D-1:0] dst, input logic [W-1:0] alu,
                               input logic [W-1:0] val);
      ins_t i;
      i.rd = rd; i.wr = wr; i.wben = wben; i.dst = dst; i.alu = alu; i.val = val;
      return i;
   endfunction

   task automatic apply(input ins_t i);
      mem_read_in  = i.rd;
      mem_write_in = i.wr;
      WB_en_in     = i.wben;
      dst_in       = i.dst;
      ALU_res_in   = i.alu;
      val_Rm_in    = i.val;
   endtask

   task automatic model_clear();
      m_dst = '0; m_alu = '0; m_res = '0; m_rd = 1'b0; m_en = 1'b0; m_err = 1'b0;
   endtask

   task automatic idle_expect();
      e_freeze = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
   endtask

   // One non-memory instruction: passes straight through, no freeze.
   task automatic nop_cycle(input ins_t i, input logic stray_ack);
      apply(i);
      mem_ack   = stray_ack;
      mem_rdata = $urandom;
      idle_expect();
      @(posedge clk); #1;
      m_dst = i.dst; m_alu = i.alu; m_res = '0; m_rd = i.rd; m_en = i.wben;
   endtask

   // One load/store. lat = BUSY cycle carrying mem_ack (lat > TO: never acked).
   // abort_at > 0 asserts rst during that BUSY cycle.
   task automatic mem_access(input ins_t i, input int lat, input logic [W-1:0] rdata,
                             input int abort_at);
      logic         to;
      int           k;
      logic [W-1:0] addr_exp;
      to       = (lat > TO);
      k        = to ? TO : lat;
      addr_exp = (i.alu - W'(OFF)) & ~W'(3);
      apply(i);
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      idle_expect();
      e_freeze  = 1'b1;
      @(posedge clk); #1;
      m_en = 1'b0; m_rd = 1'b0;
      for (int b = 1; b <= k; b++) begin
         mem_ack   = !to && (b == k);
         mem_rdata = (b == k) ? rdata : $urandom;
         e_freeze = 1'b1; e_req = 1'b1; e_we = i.wr; e_addr = addr_exp; e_wdata = i.val;
         if (b == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            apply('0);
            mem_ack = 1'b0;
            model_clear();
            idle_expect();
            return;
         end
         @(posedge clk); #1;
      end
      if (to) m_err = 1'b1;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      idle_expect();
      @(posedge clk); #1;
      m_dst = i.dst; m_alu = i.alu; m_rd = i.rd; m_en = i.wben;
      m_res = (i.rd && !i.wr && !to) ? rdata : '0;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst = 1'b1;
      apply('0);
      mem_ack = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      idle_expect();
      chk_en = 1'b1;
      nop_cycle('0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_freeze"},  W'(freeze),       '0);
      check({tag, "_req"},     W'(mem_req),      '0);
      check({tag, "_dst"},     W'(dst_out),      '0);
      check({tag, "_alu"},     ALU_res_out,      '0);
      check({tag, "_res"},     mem_result_out,   '0);
      check({tag, "_rd"},      W'(mem_read_out), '0);
      check({tag, "_wben"},    W'(WB_en_out),    '0);
      check({tag, "_err"},     W'(err_out),      '0);
   endtask

   initial begin
      ins_t i;
      int   r;
      rst = 1'b1;
      apply('0);
      mem_ack = 1'b0;
      mem_rdata = '0;
      model_clear();
      idle_expect();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all_zero("reset");
      chk_en = 1'b1;
      nop_cycle('0, 1'b0);

      // ALU op passes with one-cycle latency
      nop_cycle(mk(1'b0, 1'b0, 1'b1, 4'd3, 32'h5, 32'h0), 1'b0);
      check("alu_op_res", ALU_res_out, 32'h5);
      check("alu_op_dst", W'(dst_out), 32'd3);
      check("alu_op_wben", W'(WB_en_out), 32'd1);

      // load acked in the third BUSY cycle
      fz_cnt = 0;
      mem_access(mk(1'b1, 1'b0, 1'b1, 4'd2, 32'd1028, 32'h0), 3, 32'hCAFE0001, 0);
      check("load_freeze_len", W'(fz_cnt), 32'd4);
      check("load_addr", obs_addr, 32'd4);
      check("load_result", mem_result_out, 32'hCAFE0001);
      check("load_rd_sel", W'(mem_read_out), 32'd1);

      // store with WB disabled, unaligned effective address
      mem_access(mk(1'b0, 1'b1, 1'b0, 4'd1, 32'd1030, 32'h77), 2, $urandom, 0);
      check("store_addr", obs_addr, 32'd4);
      check("store_we", W'(obs_we), 32'd1);
      check("store_wdata", obs_wdata, 32'h77);
      check("store_wben", W'(WB_en_out), 32'd0);

      // stray acks while idle change nothing
      nop_cycle(mk(1'b0, 1'b0, 1'b1, 4'd5, 32'h123, 32'h0), 1'b1);
      nop_cycle(mk(1'b0, 1'b0, 1'b1, 4'd5, 32'h123, 32'h0), 1'b1);
      check("stray_ack_alu", ALU_res_out, 32'h123);
      check("stray_ack_res", mem_result_out, 32'h0);

      // load never acked: timeout after TO BUSY cycles
      fz_cnt = 0;
      mem_access(mk(1'b1, 1'b0, 1'b1, 4'd6, 32'd2000, 32'h0), 9, 32'hDEAD, 0);
      check("timeout_freeze_len", W'(fz_cnt), 32'd5);
      check("timeout_result", mem_result_out, 32'h0);
      check("timeout_err", W'(err_out), 32'd1);
      repeat (3) nop_cycle(mk(1'b0, 1'b0, 1'b1, 4'($urandom), $urandom, $urandom), 1'b0);
      check("err_sticky", W'(err_out), 32'd1);

      // reset during the second BUSY cycle
      mem_access(mk(1'b1, 1'b0, 1'b1, 4'd7, 32'd4096, 32'h0), 3, 32'hBEEF, 2);
      check_all_zero("busy_reset");
      nop_cycle('0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            do_reset();
         end else if (r < 50) begin
            nop_cycle(mk(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom),
                      1'($urandom_range(0, 1)));
         end else begin
            i = mk(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
            case ($urandom_range(0, 2))
               0:       i.rd = 1'b1;
               1:       i.wr = 1'b1;
               default: begin i.rd = 1'b1; i.wr = 1'b1; end
            endcase
            mem_access(i, int'($urandom_range(1, 6)), $urandom, 0);
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
